// File: rtl/fe_pc_sequencer.sv
// Fetch PC sequencer: owns the PC register and the FE latch handed to decode,
// applies taken redirects (squashing FE/DE) and honours decode stalls.
module fe_pc_sequencer #(
    parameter int unsigned      DBITS      = 32,
    parameter logic [DBITS-1:0] START_PC   = DBITS'(32'h0000_0200),
    parameter int unsigned      INST_BYTES = 4,
    parameter int unsigned      RCNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect_valid,
    input  logic [DBITS-1:0]     redirect_pc,
    input  logic                 stall_DE,
    output logic [DBITS-1:0]     fetch_pc,
    output logic [DBITS-1:0]     latch_pc_FE,
    output logic [DBITS-1:0]     latch_pcplus_FE,
    output logic [DBITS-1:0]     latch_inst_count_FE,
    output logic                 latch_valid_FE,
    output logic                 squash_DE,
    output logic                 misalign_err,
    output logic [RCNT_BITS-1:0] redirect_count
);

    logic [DBITS-1:0] inst_count_q;
    logic [DBITS-1:0] pc_seq;

    assign pc_seq    = fetch_pc + DBITS'(INST_BYTES);
    assign squash_DE = redirect_valid;

    // Priority: redirect over stall over advance; redirect leaves inst_count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc            <= START_PC;
            inst_count_q        <= '0;
            latch_pc_FE         <= '0;
            latch_pcplus_FE     <= '0;
            latch_inst_count_FE <= '0;
            latch_valid_FE      <= 1'b0;
            misalign_err        <= 1'b0;
            redirect_count      <= '0;
        end else if (redirect_valid) begin
            fetch_pc       <= {redirect_pc[DBITS-1:2], 2'b00};
            latch_valid_FE <= 1'b0;
            misalign_err   <= misalign_err | (redirect_pc[1:0] != 2'b00);
            if (redirect_count != '1) begin
                redirect_count <= redirect_count + RCNT_BITS'(1);
            end
        end else if (!stall_DE) begin
            latch_pc_FE         <= fetch_pc;
            latch_pcplus_FE     <= pc_seq;
            latch_inst_count_FE <= inst_count_q;
            latch_valid_FE      <= 1'b1;
            fetch_pc            <= pc_seq;
            inst_count_q        <= inst_count_q + DBITS'(1);
        end
    end

endmodule

// File: tb/tb_fe_pc_sequencer.sv
// Directed bench for fe_pc_sequencer: stimulus pushes expected FE-latch contents,
// a negedge monitor pops and compares each newly latched instruction.
module tb_fe_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcplus;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall_DE = 1'b0;
    logic [31:0] fetch_pc;
    logic [31:0] latch_pc_FE;
    logic [31:0] latch_pcplus_FE;
    logic [31:0] latch_inst_count_FE;
    logic        latch_valid_FE;
    logic        squash_DE;
    logic        misalign_err;
    logic [15:0] redirect_count;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    fe_pc_sequencer #(
        .DBITS(32), .START_PC(32'h0000_0200), .INST_BYTES(4), .RCNT_BITS(16)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_DE(stall_DE),
        .fetch_pc(fetch_pc), .latch_pc_FE(latch_pc_FE), .latch_pcplus_FE(latch_pcplus_FE),
        .latch_inst_count_FE(latch_inst_count_FE), .latch_valid_FE(latch_valid_FE),
        .squash_DE(squash_DE), .misalign_err(misalign_err), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic st);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall_DE       = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic st);
        drive(rv, rpc, st);
        tick();
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pcplus, input logic [31:0] cnt);
        exp_q.push_back({pc, pcplus, cnt});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fetch_pc"}, fetch_pc, 32'h200);
        chk({tag, "_latch_pc"}, latch_pc_FE, 32'h0);
        chk({tag, "_latch_pcplus"}, latch_pcplus_FE, 32'h0);
        chk({tag, "_latch_cnt"}, latch_inst_count_FE, 32'h0);
        chk({tag, "_valid"}, 32'(latch_valid_FE), 32'h0);
        chk({tag, "_misalign"}, 32'(misalign_err), 32'h0);
        chk({tag, "_rcount"}, 32'(redirect_count), 32'h0);
    endtask

    // Monitor: a new instruction is presented when valid rises or the tag changes.
    initial begin
        logic        prev_valid;
        logic [31:0] prev_cnt;
        exp_t        e;
        prev_valid = 1'b0;
        prev_cnt   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (latch_valid_FE && (!prev_valid || latch_inst_count_FE != prev_cnt)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_latch: got pc 0x%08h cnt %0d expected none",
                                 latch_pc_FE, latch_inst_count_FE);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_latch_pc", latch_pc_FE, e.pc);
                        chk("mon_latch_pcplus", latch_pcplus_FE, e.pcplus);
                        chk("mon_latch_cnt", latch_inst_count_FE, e.cnt);
                    end
                end
                prev_valid = latch_valid_FE;
                prev_cnt   = latch_inst_count_FE;
            end
        end
    end

    initial begin
        // Reset and initial state
        drive(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_reset_state("rst");

        // Free run: 0x200, 0x204, 0x208, then 0x20C
        push(32'h200, 32'h204, 0); step(0, 0, 0);
        push(32'h204, 32'h208, 1); step(0, 0, 0);
        push(32'h208, 32'h20C, 2); step(0, 0, 0);
        chk("free_fetch_pc", fetch_pc, 32'h20C);
        chk("free_valid", 32'(latch_valid_FE), 32'h1);
        push(32'h20C, 32'h210, 3); step(0, 0, 0);

        // Stall 3 cycles at PC 0x210: everything frozen
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            chk("stall_fetch_pc", fetch_pc, 32'h210);
            chk("stall_latch_pc", latch_pc_FE, 32'h20C);
            chk("stall_latch_cnt", latch_inst_count_FE, 32'h3);
        end
        push(32'h210, 32'h214, 4); step(0, 0, 0);

        // Redirect during stall: squash is combinational, redirect wins
        drive(1, 32'h400, 1);
        #1;
        chk("squash_comb", 32'(squash_DE), 32'h1);
        tick();
        chk("redir_fetch_pc", fetch_pc, 32'h400);
        chk("redir_valid", 32'(latch_valid_FE), 32'h0);
        chk("redir_count1", 32'(redirect_count), 32'h1);
        drive(0, 0, 0);
        #1;
        chk("squash_low", 32'(squash_DE), 32'h0);
        push(32'h400, 32'h404, 5); tick();
        chk("post_redir_fetch", fetch_pc, 32'h404);

        // Misaligned target is truncated and sets the sticky flag
        step(1, 32'h302, 0);
        chk("mis_fetch_pc", fetch_pc, 32'h300);
        chk("mis_flag", 32'(misalign_err), 32'h1);
        push(32'h300, 32'h304, 6); step(0, 0, 0);

        // Back-to-back redirects: second wins, two increments, valid held low
        step(1, 32'h500, 0);
        step(1, 32'h600, 0);
        chk("b2b_fetch_pc", fetch_pc, 32'h600);
        chk("b2b_valid", 32'(latch_valid_FE), 32'h0);
        chk("b2b_count", 32'(redirect_count), 32'h4);
        chk("mis_sticky", 32'(misalign_err), 32'h1);
        push(32'h600, 32'h604, 7); step(0, 0, 0);

        // Redirect to the current PC still squashes and counts
        step(1, 32'h604, 0);
        chk("self_valid", 32'(latch_valid_FE), 32'h0);
        chk("self_count", 32'(redirect_count), 32'h5);
        push(32'h604, 32'h608, 8); step(0, 0, 0);

        // PC wrap at the top of the address space
        step(1, 32'hFFFF_FFFC, 0);
        push(32'hFFFF_FFFC, 32'h0, 9); step(0, 0, 0);
        chk("wrap_fetch_pc", fetch_pc, 32'h0);
        push(32'h0, 32'h4, 10); step(0, 0, 0);
        chk("wrap_fetch_pc2", fetch_pc, 32'h4);

        // Counter saturation: 6 so far, 65528 more reaches 0xFFFE
        drive(1, 32'h100, 0);
        repeat (65528) tick();
        chk("sat_fffe", 32'(redirect_count), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(redirect_count), 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", 32'(redirect_count), 32'hFFFF);
        push(32'h100, 32'h104, 11); step(0, 0, 0);
        chk("sat_mis_sticky", 32'(misalign_err), 32'h1);

        // Asynchronous reset mid-stall, checked before the next edge
        step(0, 0, 1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_state("async_rst");
        tick();
        drive(0, 0, 0);
        reset = 1'b0;
        #1;
        push(32'h200, 32'h204, 0); tick();
        chk("restart_fetch_pc", fetch_pc, 32'h204);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
